// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, default bit timing and receiver FSM states.
// Used by both ends of the link so transmitter and receiver agree on framing.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_FRAME_BITS   = 11;
    localparam int UART_PARITY_EVEN  = 1;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Parity bit a correct transmitter would append to this data byte.
    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data);
        return (UART_PARITY_EVEN != 0) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for asynchronous inputs, with a caller-chosen reset value
// so idle-high lines come out of reset without a false edge.
module rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= rst_val;
            dout <= rst_val;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/rx_uart.sv
// UART receiver: 2-FF synchronized line, mid-bit sampling, 8E1 deframing with status.
// Parity checking is enabled by defining RX_UART_PARITY_CHECK_EN; otherwise parity_err_o stays 0.
module rx_uart #(
    parameter int CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dato_serie_i,
    output logic [7:0] dato_rx_o,
    output logic       valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

`ifdef RX_UART_PARITY_CHECK_EN
    localparam logic PARITY_CHECK = 1'b1;
`else
    localparam logic PARITY_CHECK = 1'b0;
`endif

    logic                      rx_s;
    rx_state_t                 state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      perr;
    logic                      bit_tick;

    rx_sync #(
        .WIDTH(1)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rst_val(1'b1),
        .din    (dato_serie_i),
        .dout   (rx_s)
    );

    // After the half-bit start alignment, every full bit period lands mid-bit.
    assign bit_tick = (cnt == CNT_LAST);
    assign busy_o   = (state != RX_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            perr         <= 1'b0;
            dato_rx_o    <= 8'h00;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) state <= RX_PARITY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        perr  <= PARITY_CHECK & (rx_s ^ parity_bit(shreg));
                        state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_tick) begin
                        cnt          <= '0;
                        dato_rx_o    <= shreg;
                        parity_err_o <= perr;
                        frame_err_o  <= ~rx_s;
                        valid_o      <= 1'b1;
                        state        <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A break holds the line low; wait for it to rise so it is not seen as a new start.
                RX_WAIT_HIGH: begin
                    cnt <= '0;
                    if (rx_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: vector table, randomized frames against a frame-level model,
// and hand-written break, glitch, back-to-back and mid-frame reset sequences.
module tb_rx_uart;

    localparam int CPB = 16;
`ifdef RX_UART_PARITY_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic       clk_i;
    logic       rst_i;
    logic       dato_serie_i;
    logic [7:0] dato_rx_o;
    logic       valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       busy_o;

    rx_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dato_serie_i(dato_serie_i),
        .dato_rx_o   (dato_rx_o),
        .valid_o     (valid_o),
        .parity_err_o(parity_err_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } strobe_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] expData;
        logic       expPerr;
        logic       expFerr;
    } vec_t;

    strobe_t    strobes[$];
    int         cyc = 0;
    int         lastStart = 0;
    int         vecCount = 0;
    int         missCount = 0;
    logic [7:0] lastD = 8'h00;
    logic       lastPe = 1'b0;
    logic       lastFe = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Every cycle valid_o is seen high becomes one strobe record.
    always @(negedge clk_i) begin
        if (valid_o) strobes.push_back('{dato_rx_o, parity_err_o, frame_err_o, cyc});
    end

    task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        vecCount++;
        if (act < lo || act > hi) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Drives one full 11-bit frame starting at a falling clock edge.
    task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        lastStart = cyc;
        for (int i = 0; i < 11; i++) begin
            dato_serie_i = bits[i];
            repeat (CPB) @(negedge clk_i);
        end
    endtask

    // Frame-level reference: what a receiver must report for a given byte, parity bit and stop bit.
    function automatic logic [9:0] model(input logic [7:0] d, input logic p, input logic s);
        logic evenOnes;
        logic pe;
        evenOnes = ($countones(d) % 2) == 0;
        pe = PCHK && (p != (evenOnes ? 1'b0 : 1'b1));
        return {d, pe, ~s};
    endfunction

    task automatic checkFrame(input string name, input logic [7:0] ed, input logic ep, input logic ef);
        checkOutput({name, " strobes"}, strobes.size(), 1);
        if (strobes.size() > 0) begin
            checkOutput({name, " data"}, strobes[0].d, ed);
            checkOutput({name, " parity_err"}, strobes[0].pe, ep);
            checkOutput({name, " frame_err"}, strobes[0].fe, ef);
        end
        checkOutput({name, " data held"}, dato_rx_o, ed);
        lastD = ed;
        lastPe = ep;
        lastFe = ef;
        strobes.delete();
    endtask

    vec_t vecs[7];

    initial begin
        logic [9:0] m;
        logic [7:0] rd;
        logic       rp;
        logic       rs;
        int         gap;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, PCHK, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, PCHK, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};

        rst_i = 1'b1;
        dato_serie_i = 1'b1;
        repeat (4) @(negedge clk_i);
        checkOutput("reset data", dato_rx_o, 8'h00);
        checkOutput("reset valid", valid_o, 0);
        checkOutput("reset parity_err", parity_err_o, 0);
        checkOutput("reset frame_err", frame_err_o, 0);
        checkOutput("reset busy", busy_o, 0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);

        for (int i = 0; i < 7; i++) begin
            strobes.delete();
            applyStimulus(vecs[i].data, vecs[i].par, vecs[i].stop);
            dato_serie_i = 1'b1;
            repeat (24) @(negedge clk_i);
            if (i == 0 && strobes.size() > 0)
                checkRange("latency", strobes[0].cyc - lastStart, 2 + CPB/2 + 10*CPB - 1, 2 + CPB/2 + 10*CPB + 1);
            checkFrame($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expPerr, vecs[i].expFerr);
            checkOutput($sformatf("vec%0d idle busy", i), busy_o, 0);
        end

        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(4, 30);
            strobes.delete();
            applyStimulus(rd, rp, rs);
            dato_serie_i = 1'b1;
            repeat (gap) @(negedge clk_i);
            m = model(rd, rp, rs);
            checkFrame($sformatf("rand%0d", i), m[9:2], m[1], m[0]);
        end
        repeat (24) @(negedge clk_i);

        // Break: stop bit low and line held low afterwards.
        strobes.delete();
        applyStimulus(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk_i);
        checkOutput("break busy while low", busy_o, 1);
        checkOutput("break strobes while low", strobes.size(), 1);
        dato_serie_i = 1'b1;
        repeat (24) @(negedge clk_i);
        checkOutput("break busy after rise", busy_o, 0);
        m = model(8'h3C, 1'b0, 1'b0);
        checkFrame("break", m[9:2], m[1], m[0]);

        // Short low glitch on an idle line.
        dato_serie_i = 1'b0;
        repeat (5) @(negedge clk_i);
        checkOutput("glitch busy during", busy_o, 1);
        dato_serie_i = 1'b1;
        repeat (20) @(negedge clk_i);
        checkOutput("glitch busy after", busy_o, 0);
        checkOutput("glitch strobes", strobes.size(), 0);
        checkOutput("glitch data kept", dato_rx_o, lastD);
        checkOutput("glitch parity_err kept", parity_err_o, lastPe);
        checkOutput("glitch frame_err kept", frame_err_o, lastFe);

        // Back-to-back frames with no idle gap.
        strobes.delete();
        applyStimulus(8'h55, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1'b1);
        dato_serie_i = 1'b1;
        repeat (24) @(negedge clk_i);
        checkOutput("b2b strobes", strobes.size(), 2);
        if (strobes.size() == 2) begin
            checkRange("b2b spacing", strobes[1].cyc - strobes[0].cyc, 11*CPB - 1, 11*CPB + 1);
            checkOutput("b2b first data", strobes[0].d, 8'h55);
            checkOutput("b2b first errors", {strobes[0].pe, strobes[0].fe}, 0);
            checkOutput("b2b second data", strobes[1].d, 8'hFF);
            checkOutput("b2b second errors", {strobes[1].pe, strobes[1].fe}, 0);
        end
        strobes.delete();

        // Reset during data bit 4 of 8'hC3; the sender aborts along with it.
        begin
            logic [10:0] bits;
            bits = {1'b1, 1'b0, 8'hC3, 1'b0};
            for (int i = 0; i < 5; i++) begin
                dato_serie_i = bits[i];
                repeat (CPB) @(negedge clk_i);
            end
            dato_serie_i = bits[5];
            repeat (CPB/2) @(negedge clk_i);
            rst_i = 1'b1;
            dato_serie_i = 1'b1;
            @(negedge clk_i);
            rst_i = 1'b0;
        end
        checkOutput("midreset data", dato_rx_o, 8'h00);
        checkOutput("midreset busy", busy_o, 0);
        repeat (3*CPB) @(negedge clk_i);
        checkOutput("midreset strobes", strobes.size(), 0);
        checkOutput("midreset flags", {parity_err_o, frame_err_o}, 0);
        applyStimulus(8'h81, 1'b0, 1'b1);
        dato_serie_i = 1'b1;
        repeat (24) @(negedge clk_i);
        checkFrame("after reset", 8'h81, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/rx_uart.md
# rx_uart

Serial UART receiver, the downstream partner of the team's UART transmitter. Samples the asynchronous line `dato_serie_i` with a 2-FF synchronizer and mid-bit sampling. Deframes 11-bit frames (start 0, 8 data bits LSB first, even parity, stop 1). Delivers each byte with a one-cycle valid strobe plus parity and framing status to the downstream consumer.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; set equal to the transmitter's per-bit cycle count; minimum 4.
- `clk_i  input  1`: single clock, all logic on rising edge.
- `rst_i  input  1`: synchronous, active-high reset.
- `dato_serie_i  input  1`: asynchronous serial line, idle high.
- `dato_rx_o  output  8`: last received byte, held until the next frame completes.
- `valid_o  output  1`: one-cycle strobe when a frame completes, including frames with errors.
- `parity_err_o  output  1`: parity status of the last frame; 1 = received parity bit ≠ XOR of data bits.
- `frame_err_o  output  1`: framing status of the last frame; 1 = stop bit sampled low.
- `busy_o  output  1`: high from validated start bit until return to IDLE.

## Operation
- Synchronizer: 2 flops on `dato_serie_i`, both reset to 1. The FSM sees only the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE → START: on `rx_s` = 0. Clear baud counter.
- START: at count `CLKS_PER_BIT/2 - 1` (mid start bit), sample `rx_s`.
  - If 1, treat it as a glitch: go to IDLE, no strobe, status unchanged.
  - If 0, reset the counter and go to DATA.
- DATA: sample every `CLKS_PER_BIT` cycles (mid-bit). Shift into `shreg[7:0]` LSB first; a 3-bit index counts 0..7. After bit 7 → PARITY.
- PARITY: sample one bit mid-bit; compute `perr` = sample ^ (^shreg). → STOP.
- STOP: sample mid-bit.
  - Load `dato_rx_o` ← shreg, `parity_err_o` ← perr, `frame_err_o` ← ~sample. Pulse `valid_o`.
  - If sample = 1 → IDLE; else → WAIT_HIGH.
- WAIT_HIGH: a held-low line (break) must not retrigger. Remain until `rx_s` = 1, then → IDLE.
- Baud counter width `$clog2(CLKS_PER_BIT)`. Wraps to 0 at `CLKS_PER_BIT-1`, never saturates.
- `busy_o` = state ∉ {IDLE}; WAIT_HIGH counts as busy.

## Timing
- Reset values:
  - `dato_rx_o` = 8'h00, `valid_o` = 0, `parity_err_o` = 0, `frame_err_o` = 0, `busy_o` = 0.
  - FSM = IDLE, synchronizer = 2'b11.
- Reset asserted mid-frame: the same cycle's edge forces all of the above; the partial byte is discarded, no strobe.
- Latency: start edge on pin → IDLE exits 2 cycles later (synchronizer).
- `valid_o` rises `2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT` cycles after the pin's falling start edge, ±1 cycle of synchronizer phase.
- `valid_o` is high exactly one cycle. Data and status registers update on the same edge and are stable for ≥1 full frame.
- Back-to-back frames: after a good stop the FSM is in IDLE half a bit early. A start edge arriving immediately after the stop bit is accepted; no gap is required.
- No backpressure: a consumer that misses `valid_o` loses the byte (overrun not flagged).

## Configuration
- Macro `RX_UART_PARITY_CHECK_EN`.
- Defined: parity is compared as above, and `parity_err_o` reflects the result.
- Undefined: the parity bit slot is still consumed (frame stays 11 bits, timing unchanged), and `parity_err_o` is tied 0.

## Structure
- Shared package/include `uart_pkg`:
  - FSM state encodings.
  - `UART_DATA_BITS` = 8, `UART_FRAME_BITS` = 11, `UART_PARITY_EVEN` = 1.
  - Default `CLKS_PER_BIT` = 16, shared with the transmitter so both ends agree.
- Sub-module `rx_sync`: parameterizable 2-FF synchronizer with reset value input. It is reused later for other asynchronous inputs.

## Test plan
- Frame byte 8'hA5, parity 0, stop 1 at 16 clk/bit → one `valid_o`, `dato_rx_o` = 8'hA5, `parity_err_o` = 0, `frame_err_o` = 0.
- Byte 8'h01 sent with wrong parity 0 → `dato_rx_o` = 8'h01, `parity_err_o` = 1 (0 when macro undefined), `frame_err_o` = 0.
- Byte 8'h3C with stop bit 0, line then held low 40 cycles → one strobe, `frame_err_o` = 1, `busy_o` stays 1 until the line rises, no second strobe.
- 5-cycle low glitch on idle line → no `valid_o`, `busy_o` returns 0 at mid start bit, outputs unchanged.
- Back-to-back 8'h55 then 8'hFF with no idle gap → two strobes, spaced 11*16 ±1 cycles, correct bytes, no errors.
- `rst_i` pulsed during data bit 4 of 8'hC3, then clean 8'h81 → no strobe for the first frame, second received as 8'h81, all status flags 0.
